// File: rtl/num_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : num_entry_pkg
//  Description : Shared types, constants and key lookup for the keypad
//                number-entry block.
//  Revision    : 1.0 - initial release
// ============================================================================
package num_entry_pkg;

    // Scanner/debounce FSM states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // Active-low column strobe patterns, index 0..3
    localparam logic [3:0] COL_0 = 4'b1110;
    localparam logic [3:0] COL_1 = 4'b1101;
    localparam logic [3:0] COL_2 = 4'b1011;
    localparam logic [3:0] COL_3 = 4'b0111;

    // Key codes: digits carry their own BCD value
    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    // Column index to strobe pattern
    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        case (idx)
            2'd0:    return COL_0;
            2'd1:    return COL_1;
            2'd2:    return COL_2;
            default: return COL_3;
        endcase
    endfunction

    // Matrix position to key code; *, # and D carry no action
    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        case ({row_idx, col_idx})
            4'b00_00: return KEY_1;
            4'b00_01: return KEY_2;
            4'b00_10: return KEY_3;
            4'b00_11: return KEY_ENTER;
            4'b01_00: return KEY_4;
            4'b01_01: return KEY_5;
            4'b01_10: return KEY_6;
            4'b01_11: return KEY_BKSP;
            4'b10_00: return KEY_7;
            4'b10_01: return KEY_8;
            4'b10_10: return KEY_9;
            4'b10_11: return KEY_CLR;
            4'b11_01: return KEY_0;
            default:  return KEY_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 active-low matrix scanner with tick divider, row
//                synchronizer and press/release debounce. Emits one
//                key_strobe per physical press.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import num_entry_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_strobe
);

    localparam int         TW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [TW-1:0] r_tick;
    logic          w_tick;
    logic          w_one_low;
    logic [1:0]    w_row_idx;
    logic          w_same;
    logic [3:0]    w_db_next;
    state_t        r_state;
    logic [3:0]    r_row_lat;
    logic [1:0]    r_row_idx;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_db_cnt;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Free-running scan tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tick <= '0;
        else if (w_tick)
            r_tick <= '0;
        else
            r_tick <= r_tick + 1'b1;
    end

    assign w_tick    = (r_tick == TW'(SCAN_DIV - 1));
    assign w_same    = w_one_low && (r_row_sync == r_row_lat);
    assign w_db_next = r_db_cnt + 4'd1;

    // Exactly-one-low row decode; anything else is treated as no key
    always_comb begin
        w_one_low = 1'b1;
        w_row_idx = 2'd0;
        case (r_row_sync)
            4'b1110: w_row_idx = 2'd0;
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    // Scan/debounce FSM; col is frozen outside SCAN so the latched key stays sensed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SCAN;
            r_row_lat  <= 4'hF;
            r_row_idx  <= 2'd0;
            r_col_idx  <= 2'd0;
            r_db_cnt   <= 4'd0;
            col        <= COL_0;
            key_code   <= KEY_NONE;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_one_low) begin
                            r_row_lat <= r_row_sync;
                            r_row_idx <= w_row_idx;
                            r_db_cnt  <= 4'd1;
                            if (DB_MAX == 4'd1) begin
                                key_code   <= key_lookup(w_row_idx, r_col_idx);
                                key_strobe <= 1'b1;
                                r_state    <= HELD;
                            end else begin
                                r_state <= PRESS_DB;
                            end
                        end else begin
                            r_col_idx <= r_col_idx + 2'd1;
                            col       <= col_pattern(r_col_idx + 2'd1);
                        end
                    end
                    PRESS_DB: begin
                        if (w_same) begin
                            r_db_cnt <= w_db_next;
                            if (w_db_next == DB_MAX) begin
                                key_code   <= key_lookup(r_row_idx, r_col_idx);
                                key_strobe <= 1'b1;
                                r_state    <= HELD;
                            end
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!w_one_low) begin
                            r_db_cnt <= 4'd1;
                            if (DB_MAX == 4'd1) begin
                                r_state   <= SCAN;
                                r_col_idx <= r_col_idx + 2'd1;
                                col       <= col_pattern(r_col_idx + 2'd1);
                            end else begin
                                r_state <= REL_DB;
                            end
                        end
                    end
                    default: begin
                        if (!w_one_low) begin
                            r_db_cnt <= w_db_next;
                            if (w_db_next == DB_MAX) begin
                                r_state   <= SCAN;
                                r_col_idx <= r_col_idx + 2'd1;
                                col       <= col_pattern(r_col_idx + 2'd1);
                            end
                        end else begin
                            r_state <= HELD;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/num_entry.sv
`default_nettype none
// ============================================================================
//  Module      : num_entry
//  Description : Keypad number entry. Assembles up to four BCD digits from
//                keypad strokes and commits them as a binary value.
//                Option macro NUM_ENTRY_LIVE_EN: value follows the live entry
//                and pulses on every digit/Backspace/Clear; Enter only clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module num_entry
    import num_entry_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [2:0]  digit_count
);

    logic        r_rst_meta;
    logic        r_rst_sync;
    logic        w_rst_n;
    logic [3:0]  w_key_code;
    logic        w_key_strobe;
    logic [15:0] r_bcd;
    logic [15:0] w_bcd_shift;
    logic [15:0] w_bcd_bksp;

    // Reset synchronizer: asserts immediately, releases on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .row        (row),
        .col        (col),
        .key_code   (w_key_code),
        .key_strobe (w_key_strobe)
    );

    // Four BCD digits to binary with constant multiplies; max 9999 fits 14 bits
    function automatic logic [15:0] bcd2bin(input logic [15:0] bcd);
        logic [13:0] bin;
        bin = 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
            + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
        return {2'b00, bin};
    endfunction

    assign w_bcd_shift = {r_bcd[11:0], w_key_code};
    assign w_bcd_bksp  = {4'h0, r_bcd[15:4]};

    // Key action decode: digit entry, Enter, Backspace, Clear
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bcd       <= 16'h0000;
            digit_count <= 3'd0;
            value       <= 16'd0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (w_key_strobe) begin
                case (w_key_code)
                    KEY_ENTER: begin
                        r_bcd       <= 16'h0000;
                        digit_count <= 3'd0;
`ifdef NUM_ENTRY_LIVE_EN
`else
                        value       <= bcd2bin(r_bcd);
                        value_valid <= 1'b1;
`endif
                    end
                    KEY_BKSP: begin
                        r_bcd <= w_bcd_bksp;
                        if (digit_count != 3'd0)
                            digit_count <= digit_count - 3'd1;
`ifdef NUM_ENTRY_LIVE_EN
                        value       <= bcd2bin(w_bcd_bksp);
                        value_valid <= 1'b1;
`endif
                    end
                    KEY_CLR: begin
                        r_bcd       <= 16'h0000;
                        digit_count <= 3'd0;
`ifdef NUM_ENTRY_LIVE_EN
                        value       <= 16'd0;
                        value_valid <= 1'b1;
`endif
                    end
                    default: begin
                        if ((w_key_code <= KEY_9) && (digit_count < 3'd4)) begin
                            r_bcd       <= w_bcd_shift;
                            digit_count <= digit_count + 3'd1;
`ifdef NUM_ENTRY_LIVE_EN
                            value       <= bcd2bin(w_bcd_shift);
                            value_valid <= 1'b1;
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_num_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_num_entry
//  Description : Scoreboard bench for num_entry with a behavioural key matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_num_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value;
    logic        value_valid;
    logic [2:0]  digit_count;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int exp_v;
    logic prev_valid = 1'b0;

    logic       key_on    = 1'b0;
    logic [1:0] key_r     = 2'd0;
    logic [1:0] key_c     = 2'd0;
    logic       bounce_hi = 1'b0;
    logic       dbl_on    = 1'b0;

    num_entry #(
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .value       (value),
        .value_valid (value_valid),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row = 4'hF;
        if (key_on && !bounce_hi && (col[key_c] == 1'b0))
            row[key_r] = 1'b0;
        if (dbl_on && (col[0] == 1'b0))
            row = 4'b1100;
    end

    // Monitor: every value_valid pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && value_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual=%0d required=no_pulse", value);
            end else begin
                exp_v = exp_q.pop_front();
                if (int'(value) != exp_v) begin
                    failures++;
                    $display("FAIL committed_value actual=%0d required=%0d", value, exp_v);
                end else if (prev_valid) begin
                    failures++;
                    $display("FAIL valid_width actual=2+cycles required=1");
                end
            end
        end
        prev_valid = value_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_at(input int r, input int c);
        key_r  = 2'(r);
        key_c  = 2'(c);
        key_on = 1'b1;
        wait_cyc(40);
        key_on = 1'b0;
        wait_cyc(40);
    endtask

    // Keys: 'A' Enter, 'B' Backspace, 'C' Clear, '0'..'9' digits
    task automatic press(input byte k);
        case (k)
            "A": press_at(0, 3);
            "B": press_at(1, 3);
            "C": press_at(2, 3);
            "0": press_at(3, 1);
            default: press_at((int'(k - "1")) / 3, (int'(k - "1")) % 3);
        endcase
    endtask

    logic [3:0] col_seq [4];
    logic [3:0] col_prev;
    int         t;

    initial begin
        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset state
        wait_cyc(3);
        check("reset_col", int'(col), 4'b1110);
        check("reset_value", int'(value), 0);
        check("reset_valid", int'(value_valid), 0);
        check("reset_count", int'(digit_count), 0);
        rst_n = 1'b1;

        // Idle column rotation, four cycles per step once running
        col_prev = col;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (col == col_prev && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("col_step", int'(col), int'(col_seq[i]));
            if (i > 0) check("col_period", t, 4);
            col_prev = col;
        end

        // 1 2 3 4 Enter -> 1234
        press("1"); press("2"); press("3"); press("4");
        check("count_four", int'(digit_count), 4);
        exp_q.push_back(1234);
        press("A");
        check("count_after_enter", int'(digit_count), 0);
        check("value_1234", int'(value), 1234);

        // Fifth digit ignored -> 9876
        press("9"); press("8"); press("7"); press("6"); press("5");
        check("count_saturate", int'(digit_count), 4);
        exp_q.push_back(9876);
        press("A");
        check("value_9876", int'(value), 9876);

        // 4 2 Bksp 7 Enter -> 47
        press("4"); press("2"); press("B");
        check("count_bksp", int'(digit_count), 1);
        press("7");
        exp_q.push_back(47);
        press("A");
        check("value_47", int'(value), 47);

        // Reset while debouncing a fourth digit
        press("1"); press("2"); press("3");
        check("count_three", int'(digit_count), 3);
        key_r = 2'd1; key_c = 2'd0; key_on = 1'b1;
        t = 0;
        while (dut.u_scanner.r_state != num_entry_pkg::PRESS_DB && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_press_db", int'(t < 100), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_col", int'(col), 4'b1110);
        check("mid_reset_value", int'(value), 0);
        check("mid_reset_valid", int'(value_valid), 0);
        check("mid_reset_count", int'(digit_count), 0);
        key_on = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(10);
        check("post_reset_count", int'(digit_count), 0);
        press("4");
        check("fresh_press_count", int'(digit_count), 1);
        exp_q.push_back(4);
        press("A");
        check("value_4", int'(value), 4);

        // 5 Clear Enter -> 0
        press("5"); press("C");
        check("count_clear", int'(digit_count), 0);
        check("clear_keeps_value", int'(value), 4);
        exp_q.push_back(0);
        press("A");
        check("value_0", int'(value), 0);

        // Bouncing press of '1' -> exactly one digit
        key_r = 2'd0; key_c = 2'd0; bounce_hi = 1'b0; key_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bounce_hi = ~bounce_hi;
            @(negedge clk);
        end
        bounce_hi = 1'b0;
        wait_cyc(40);
        key_on = 1'b0;
        wait_cyc(40);
        check("bounce_count", int'(digit_count), 1);
        exp_q.push_back(1);
        press("A");
        check("value_bounce", int'(value), 1);

        // Two rows low together -> no action
        dbl_on = 1'b1;
        wait_cyc(60);
        dbl_on = 1'b0;
        wait_cyc(40);
        check("double_row_count", int'(digit_count), 0);
        check("double_row_value", int'(value), 1);

        wait_cyc(5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/num_entry.md
# num_entry

Keypad number-entry block: the input-side counterpart of the four-digit seven-segment display driver. It scans a 4x4 active-low key matrix and debounces presses. Decimal keystrokes are assembled into four BCD digits, which are converted to a 16-bit binary value on Enter. `value` drives the display driver's `value` input directly, so the operator sees the number they committed.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per scan tick, the same multiplex rate as the display.
- `DEBOUNCE`, default 4: consecutive scan ticks a key state must be stable before it is accepted (range 1..15).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `row` in 4: matrix row sense, active-low, asynchronous to `clk`.
- `col` out 4: column strobe, active-low, one-hot-zero.
- `value` out 16: last committed binary value, 0..9999.
- `value_valid` out 1: one-cycle pulse when `value` updates.
- `digit_count` out 3: number of digits currently in entry, 0..4.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column rotation is 1110 → 1101 → 1011 → 0111 → 1110, one step per tick, but only while the FSM is in SCAN.
- Key map is indexed as (row, col index): row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = * 0 # D.
- Key actions:
  - Digit 0-9 with `digit_count` < 4: shift the BCD digits left, insert the new digit at d0, increment `digit_count`.
  - Digit with `digit_count` = 4: ignored.
  - A (Enter): `value` = d3·1000 + d2·100 + d1·10 + d0. `value_valid` pulses. Digits and count clear.
  - B (Backspace): shift digits right, d3 = 0, decrement count (saturates at 0).
  - C (Clear): digits and count go to 0; `value` is unchanged.
  - *, #, D: no action.
- A sampled row pattern with zero or with more than one low bit counts as "no key".
- FSM states and transitions:
  - SCAN: at each tick, if exactly one row is low, latch the row and column, go to PRESS_DB with the counter at 1. Otherwise advance the column.
  - PRESS_DB: `col` is held. At each tick, the same single row low increments the counter; anything else returns to SCAN. When the counter reaches `DEBOUNCE`, apply the key action on that edge and go to HELD.
  - HELD: `col` is held. At the first tick with no key, go to REL_DB with the counter at 1.
  - REL_DB: at each tick, no key increments the counter, any key returns to HELD. When the counter reaches `DEBOUNCE`, go to SCAN and advance the column.
- Each physical press produces exactly one action; there is no auto-repeat.
- The BCD-to-binary conversion uses constant multiplies only. The result fits in 14 bits and is zero-extended to 16.

## Timing
- Reset values: `col` = 1110, `value` = 0, `value_valid` = 0, `digit_count` = 0, digits 0, state SCAN, tick and debounce counters 0.
- The tick counter runs 0..`SCAN_DIV`-1 and the tick fires on the wrap. It never stops, including outside SCAN.
- Press latency, from `row` low to the action edge: 2 sync cycles + up to `SCAN_DIV`·4 cycles to reach the column + (`DEBOUNCE`-1)·`SCAN_DIV` cycles.
- `value`, the digits and `digit_count` all change on the action edge. `value_valid` is high for exactly that one cycle.
- Reset asserted mid-press or mid-debounce clears everything immediately and discards the pending key. Deassertion is synchronous to `clk` through the standard reset synchronizer.

## Configuration
- `NUM_ENTRY_LIVE_EN` defined: `value` tracks the live entry. It is recomputed and `value_valid` pulses on every digit, Backspace and Clear action. Enter then only clears the digits and leaves `value` unchanged.
- `NUM_ENTRY_LIVE_EN` undefined: `value` changes only on Enter.

## Structure
- Shared package `num_entry_pkg` holds:
  - the state enum (SCAN, PRESS_DB, HELD, REL_DB);
  - the column pattern constants;
  - the 4-bit key codes (KEY_0..KEY_9, KEY_ENTER, KEY_BKSP, KEY_CLR, KEY_NONE);
  - the row/column-to-key-code lookup function.
- Sub-module `keypad_scanner` contains the tick counter, synchronizer, FSM and debounce. It outputs `key_code` plus a one-cycle `key_strobe`.
- The top level holds the BCD digit register, the action decode and the BCD-to-binary conversion.

## Test plan
All scenarios run with `SCAN_DIV` = 4 and `DEBOUNCE` = 2.
- Reset, no keys → `col` rotates 1110, 1101, 1011, 0111 every 4 cycles; `value` = 0, `value_valid` never pulses.
- Press 1, 2, 3, 4, A (each held ≥ 3 ticks, released ≥ 3 ticks) → `value` = 1234, one `value_valid` pulse, `digit_count` back to 0.
- Press 9, 8, 7, 6, 5, A → fifth digit ignored, `value` = 9876.
- Press 4, 2, B, 7, A → `value` = 47; then press 5, C, A → `value` = 0.
- Row bounces low/high every cycle for 6 cycles, then stays low → exactly one digit accepted. Two rows low together → no action.
- `rst_n` pulsed low while in PRESS_DB with `digit_count` = 3 → all outputs return to reset values immediately; the held key, after release and a fresh press, is accepted normally.
